// File: rtl/booth_digit_encoder.sv
// booth_digit_encoder
//   Radix-4 Booth encoder for an 8-bit signed activation. It produces four
//   digit-select codes and per-digit enables for the partial-product selector.
//   The encoded word sits in an output register backed by one skid register,
//   so the block can go directly into a valid/ready feed pipeline. A
//   saturating counter totals the non-zero digits handed downstream.
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous reset, active-high
//   in_valid / in_ready    input handshake; in_ready = skid register empty
//   activation[7:0]        signed operand A
//   out_valid / out_ready  output handshake
//   partial_product_select digit i code in bits [2i+1:2i]
//                          (00 = -2 or zero, 01 = +1, 10 = +2, 11 = -1)
//   bit_enable[3:0]        bit i set when digit i is non-zero
//   nz_digits[2:0]         number of set bits in bit_enable
//   stat_clear             zero the statistics counter (wins over increment)
//   stat_nz_total          saturating sum of nz_digits over output transfers
module booth_digit_encoder #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        activation,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        partial_product_select,
  output logic [3:0]        bit_enable,
  output logic [2:0]        nz_digits,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_nz_total
);

  typedef struct packed {
    logic [7:0] sel;
    logic [3:0] en;
    logic [2:0] nz;
  } word_t;

  word_t      enc_word;
  word_t      or_q;
  word_t      sk_q;
  logic       or_valid;
  logic       sk_valid;
  logic       accept;
  logic       or_free;
  logic       out_fire;
  logic [8:0] a_ext;

  logic [STAT_W-1:0] stat_q;
  logic [STAT_W:0]   stat_sum;

  // A[-1] is the implicit zero below the LSB, so triplet i is a_ext[2i+2:2i].
  assign a_ext = {activation, 1'b0};

  always_comb begin
    enc_word = '0;
    for (int i = 0; i < 4; i++) begin
      case (a_ext[2*i +: 3])
        3'b001, 3'b010: begin
          enc_word.sel[2*i +: 2] = 2'b01;
          enc_word.en[i]         = 1'b1;
        end
        3'b011: begin
          enc_word.sel[2*i +: 2] = 2'b10;
          enc_word.en[i]         = 1'b1;
        end
        // -2 shares code 00 with zero; the enable bit tells them apart.
        3'b100: begin
          enc_word.sel[2*i +: 2] = 2'b00;
          enc_word.en[i]         = 1'b1;
        end
        3'b101, 3'b110: begin
          enc_word.sel[2*i +: 2] = 2'b11;
          enc_word.en[i]         = 1'b1;
        end
        default: begin
          enc_word.sel[2*i +: 2] = 2'b00;
          enc_word.en[i]         = 1'b0;
        end
      endcase
    end
    enc_word.nz = {2'b00, enc_word.en[0]} + {2'b00, enc_word.en[1]}
                + {2'b00, enc_word.en[2]} + {2'b00, enc_word.en[3]};
  end

  // in_ready depends only on the skid flag (and reset), never on out_ready.
  assign in_ready = ~sk_valid & ~rst;
  assign accept   = in_valid & in_ready;
  assign or_free  = ~or_valid | out_ready;
  assign out_fire = or_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
    end else if (or_free) begin
      if (sk_valid) begin
        or_q     <= sk_q;
        or_valid <= 1'b1;
        // Unreachable while in_ready = !sk_valid, but keeps FIFO order safe
        // if the ready rule is ever relaxed.
        if (accept) begin
          sk_q <= enc_word;
        end else begin
          sk_valid <= 1'b0;
        end
      end else begin
        or_valid <= accept;
        if (accept) begin
          or_q <= enc_word;
        end
      end
    end else if (accept) begin
      sk_q     <= enc_word;
      sk_valid <= 1'b1;
    end
  end

  assign out_valid              = or_valid;
  assign partial_product_select = or_valid ? or_q.sel : 8'h00;
  assign bit_enable             = or_valid ? or_q.en  : 4'h0;
  assign nz_digits              = or_valid ? or_q.nz  : 3'd0;

  // One extra bit catches the carry out, which means the sum saturated.
  assign stat_sum = {1'b0, stat_q} + {{(STAT_W-2){1'b0}}, or_q.nz};

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_q <= '0;
    end else if (out_fire) begin
      stat_q <= stat_sum[STAT_W] ? '1 : stat_sum[STAT_W-1:0];
    end
  end

  assign stat_nz_total = stat_q;

endmodule
